dmi_host_fsm: RTL and testbench



---
 rtl/dmi_host_fsm_pkg.sv | 38 +++
 rtl/dmi_host_fsm.sv | 170 +++++++++++++++++
 tb/tb_dmi_host_fsm.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_host_fsm_pkg.sv
// Debug transport types shared by the DTM-side DMI logic.
// Holds the DMI request/response channel types, the DTM op encoding,
// the sticky status codes and the layout of the DMI data-register word.
package dmi_host_fsm_pkg;

    // Sticky status codes reported through dmistat / the DR capture word.
    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

    // Operation field of a DMI access; encoding 2'h3 is reserved.
    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_t;

    // Request toward the debug module.
    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_t     op;
        logic [31:0] data;
    } dmi_req_t;

    // Response from the debug module.
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    // DMI data-register word as shifted in by the TAP.
    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
    } dmi_t;

endpackage

// File: rtl/dmi_host_fsm.sv
// DTM-side DMI initiator.
// Turns a DMI data-register update into a single request/response
// transaction toward the debug module, keeps the last address, data and
// sticky status for the next DR capture, and flags accesses that arrive
// while a transaction is still in flight.
module dmi_host_fsm
    import dmi_host_fsm_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        update_i,
    input  logic        capture_i,
    input  logic [40:0] dmi_i,
    output logic [40:0] dmi_o,
    input  logic        dmireset_i,
    input  logic        dmihardreset_i,
    output logic [1:0]  dmistat_o,
    output logic [40:0] dmi_req_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    input  logic [33:0] dmi_resp_i,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_READ,
        WRITE,
        WAIT_WRITE
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  address_q, address_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  error_q, error_d;

    dmi_t        dmi_word;
    dmi_resp_t   resp;
    dmi_req_t    req;
    logic        busy_event;
    logic        resp_failed;

    assign dmi_word = dmi_i;
    assign resp     = dmi_resp_i;

    // A DR strobe that lands while a transaction is outstanding is a busy
    // condition; it is only recorded, the transaction itself carries on.
    assign busy_event = (state_q != IDLE) && (update_i || capture_i);

    // Next-state, register-update and status logic.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path leaves it unassigned; otherwise a latch would be inferred.
        state_d     = state_q;
        address_d   = address_q;
        data_d      = data_q;
        error_d     = error_q;
        resp_failed = 1'b0;

        case (state_q)
            IDLE: begin
                // With a sticky error pending the whole update is dropped;
                // the TAP must clear the status before issuing new accesses.
                if (update_i && (error_q == DTM_SUCCESS)) begin
                    address_d = dmi_word.addr;
                    case (dmi_word.op)
                        DTM_READ: state_d = READ;
                        DTM_WRITE: begin
                            state_d = WRITE;
                            data_d  = dmi_word.data;
                        end
                        // NOP and the reserved encoding only latch the address.
                        default: state_d = IDLE;
                    endcase
                end
            end
            READ: begin
                if (dmi_req_ready_i) state_d = WAIT_READ;
            end
            WRITE: begin
                if (dmi_req_ready_i) state_d = WAIT_WRITE;
            end
            WAIT_READ: begin
                if (dmi_resp_valid_i) begin
                    state_d     = IDLE;
                    data_d      = resp.data;
                    resp_failed = (resp.resp != DTM_SUCCESS);
                end
            end
            WAIT_WRITE: begin
                if (dmi_resp_valid_i) begin
                    state_d     = IDLE;
                    resp_failed = (resp.resp != DTM_SUCCESS);
                end
            end
            default: state_d = IDLE;
        endcase

        // Status is sticky: only the first error since the last clear is
        // kept. A failed response outranks a busy strobe in the same cycle
        // because it reports an access that actually went wrong.
        if (error_q == DTM_SUCCESS) begin
            if (resp_failed) begin
                error_d = DTM_ERR;
            end else if (busy_event) begin
                error_d = DTM_BUSY;
            end
        end

        // dmireset clears the status after the update above has already
        // been judged against the old value.
        if (dmireset_i) error_d = DTM_SUCCESS;

        // dmihardreset abandons whatever is in flight and beats every
        // other event in the same cycle.
        if (dmihardreset_i) begin
            state_d   = IDLE;
            address_d = address_q;
            data_d    = data_q;
            error_d   = DTM_SUCCESS;
        end
    end

    // State and architectural registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q   <= IDLE;
            address_q <= '0;
            data_q    <= '0;
            error_q   <= DTM_SUCCESS;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            data_q    <= data_d;
            error_q   <= error_d;
        end
    end

    // Channel outputs decoded from the registered state only, so neither
    // valid nor ready depends combinationally on any input.
    always_comb begin
        req.addr         = address_q;
        req.data         = data_q;
        req.op           = DTM_NOP;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b1;
        case (state_q)
            READ: begin
                req.op           = DTM_READ;
                dmi_req_valid_o  = 1'b1;
                dmi_resp_ready_o = 1'b0;
            end
            WRITE: begin
                req.op           = DTM_WRITE;
                dmi_req_valid_o  = 1'b1;
                dmi_resp_ready_o = 1'b0;
            end
            default: ;
        endcase
    end

    assign dmi_req_o = req;
    assign dmi_o     = {address_q, data_q, error_q};
    assign dmistat_o = error_q;

endmodule

// File: tb/tb_dmi_host_fsm.sv
// Self-checking bench for dmi_host_fsm: directed scenarios with literal
// expectations followed by a randomized run, all compared on every cycle
// against a transaction-level model of the DTM host.
module tb_dmi_host_fsm;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        update_i, capture_i, dmireset_i, dmihardreset_i;
    logic [40:0] dmi_i;
    logic [40:0] dmi_o;
    logic [1:0]  dmistat_o;
    logic [40:0] dmi_req_o;
    logic        dmi_req_valid_o, dmi_req_ready_i;
    logic [33:0] dmi_resp_i;
    logic        dmi_resp_valid_i, dmi_resp_ready_o;

    int n_checks = 0;
    int n_fail   = 0;

    dmi_host_fsm dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .update_i         (update_i),
        .capture_i        (capture_i),
        .dmi_i            (dmi_i),
        .dmi_o            (dmi_o),
        .dmireset_i       (dmireset_i),
        .dmihardreset_i   (dmihardreset_i),
        .dmistat_o        (dmistat_o),
        .dmi_req_o        (dmi_req_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_resp_i       (dmi_resp_i),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // pending: request issued, not yet accepted; awaiting: accepted, waiting
    // for the response. Neither: the host is free.
    bit          m_pending, m_awaiting, m_is_read;
    logic [6:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_err;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_pending = 0; m_awaiting = 0; m_is_read = 0;
            m_addr = '0; m_data = '0; m_err = 2'h0;
        end else if (dmihardreset_i) begin
            m_pending = 0; m_awaiting = 0; m_err = 2'h0;
        end else begin
            bit busy, failed;
            logic [1:0] new_err;
            busy    = (m_pending || m_awaiting) && (update_i || capture_i);
            failed  = 0;
            new_err = m_err;
            if (m_pending) begin
                if (dmi_req_ready_i) begin
                    m_pending  = 0;
                    m_awaiting = 1;
                end
            end else if (m_awaiting) begin
                if (dmi_resp_valid_i) begin
                    m_awaiting = 0;
                    if (m_is_read) m_data = dmi_resp_i[33:2];
                    failed = (dmi_resp_i[1:0] != 2'h0);
                end
            end else if (update_i && m_err == 2'h0) begin
                m_addr = dmi_i[40:34];
                if (dmi_i[1:0] == 2'h1) begin
                    m_pending = 1; m_is_read = 1;
                end else if (dmi_i[1:0] == 2'h2) begin
                    m_pending = 1; m_is_read = 0;
                    m_data = dmi_i[33:2];
                end
            end
            if (m_err == 2'h0) begin
                if (failed) new_err = 2'h2;
                else if (busy) new_err = 2'h3;
            end
            if (dmireset_i) new_err = 2'h0;
            m_err = new_err;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the edge.
    bit compare_on = 0;
    always @(negedge clk_i) begin
        if (compare_on) begin
            check("dmi_o", {23'h0, dmi_o}, {23'h0, m_addr, m_data, m_err});
            check("dmistat", {62'h0, dmistat_o}, {62'h0, m_err});
            check("req_valid", {63'h0, dmi_req_valid_o}, {63'h0, m_pending});
            check("resp_ready", {63'h0, dmi_resp_ready_o}, {63'h0, !m_pending});
            if (m_pending)
                check("req_payload", {23'h0, dmi_req_o},
                      {23'h0, m_addr, (m_is_read ? 2'h1 : 2'h2), m_data});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        update_i = 0; capture_i = 0; dmireset_i = 0; dmihardreset_i = 0;
        dmi_req_ready_i = 0; dmi_resp_valid_i = 0;
        dmi_i = '0; dmi_resp_i = '0;
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        #12;
        // Reset values.
        check("rst_dmi_o", {23'h0, dmi_o}, 64'h0);
        check("rst_dmistat", {62'h0, dmistat_o}, 64'h0);
        check("rst_req", {23'h0, dmi_req_o}, 64'h0);
        check("rst_valid", {63'h0, dmi_req_valid_o}, 64'h0);
        check("rst_resp_ready", {63'h0, dmi_resp_ready_o}, 64'h1);
        rst_i = 1'b0;
        compare_on = 1;
        step();

        // Read with immediate ready and minimum round trip.
        dmi_i = {7'h11, 32'h0, 2'h1}; update_i = 1; dmi_req_ready_i = 1;
        step();
        update_i = 0;
        check("read_valid_c1", {63'h0, dmi_req_valid_o}, 64'h1);
        check("read_addr_c1", {57'h0, dmi_req_o[40:34]}, 64'h11);
        step();
        dmi_req_ready_i = 0;
        dmi_resp_valid_i = 1; dmi_resp_i = {32'h0003_0382, 2'h0};
        step();
        dmi_resp_valid_i = 0;
        check("read_dmi_o", {23'h0, dmi_o}, {23'h0, 7'h11, 32'h0003_0382, 2'h0});

        // Write held off by backpressure for five cycles.
        dmi_i = {7'h10, 32'h8000_0001, 2'h2}; update_i = 1;
        step();
        update_i = 0;
        for (int i = 0; i < 5; i++) begin
            check("wr_hold_valid", {63'h0, dmi_req_valid_o}, 64'h1);
            check("wr_hold_payload", {23'h0, dmi_req_o}, {23'h0, 7'h10, 2'h2, 32'h8000_0001});
            step();
        end
        dmi_req_ready_i = 1;
        step();
        dmi_req_ready_i = 0;
        dmi_resp_valid_i = 1; dmi_resp_i = {32'h5555_aaaa, 2'h0};
        step();
        dmi_resp_valid_i = 0;
        check("wr_dmi_o", {23'h0, dmi_o}, {23'h0, 7'h10, 32'h8000_0001, 2'h0});

        // Busy: capture during WaitRead, later update ignored until dmireset.
        dmi_i = {7'h05, 32'h0, 2'h1}; update_i = 1; dmi_req_ready_i = 1;
        step();
        update_i = 0;
        step();
        dmi_req_ready_i = 0;
        capture_i = 1;
        step();
        capture_i = 0;
        check("busy_stat", {62'h0, dmistat_o}, 64'h3);
        dmi_resp_valid_i = 1; dmi_resp_i = {32'h0000_0042, 2'h0};
        step();
        dmi_resp_valid_i = 0;
        dmi_i = {7'h07, 32'h0, 2'h1}; update_i = 1;
        step();
        update_i = 0;
        check("busy_no_req", {63'h0, dmi_req_valid_o}, 64'h0);
        check("busy_addr_kept", {57'h0, dmi_o[40:34]}, 64'h05);
        dmireset_i = 1;
        step();
        dmireset_i = 0;
        check("busy_cleared", {62'h0, dmistat_o}, 64'h0);

        // Failed response sticks as DTM_ERR.
        dmi_i = {7'h22, 32'h0, 2'h1}; update_i = 1; dmi_req_ready_i = 1;
        step();
        update_i = 0;
        step();
        dmi_req_ready_i = 0;
        dmi_resp_valid_i = 1; dmi_resp_i = {32'hdead_beef, 2'h2};
        step();
        dmi_resp_valid_i = 0;
        check("err_stat", {62'h0, dmistat_o}, 64'h2);
        update_i = 1; capture_i = 1; dmi_i = {7'h33, 32'h0, 2'h1};
        step();
        update_i = 0; capture_i = 0;
        check("err_sticky", {62'h0, dmistat_o}, 64'h2);
        check("err_no_req", {63'h0, dmi_req_valid_o}, 64'h0);
        dmireset_i = 1;
        step();
        dmireset_i = 0;

        // Hard reset while a request is stalled.
        dmi_i = {7'h03, 32'h1234_5678, 2'h2}; update_i = 1;
        step();
        update_i = 0;
        check("hr_valid_before", {63'h0, dmi_req_valid_o}, 64'h1);
        dmihardreset_i = 1;
        step();
        dmihardreset_i = 0;
        check("hr_valid_after", {63'h0, dmi_req_valid_o}, 64'h0);
        check("hr_stat", {62'h0, dmistat_o}, 64'h0);
        dmi_resp_valid_i = 1; dmi_resp_i = {32'hffff_0000, 2'h2};
        step();
        dmi_resp_valid_i = 0;
        check("hr_late_resp", {23'h0, dmi_o}, {23'h0, 7'h03, 32'h1234_5678, 2'h0});

        // Asynchronous reset in the middle of a write request.
        dmi_i = {7'h7f, 32'h0000_cafe, 2'h2}; update_i = 1;
        step();
        update_i = 0;
        #2 rst_i = 1'b1;
        #1;
        check("arst_dmi_o", {23'h0, dmi_o}, 64'h0);
        check("arst_valid", {63'h0, dmi_req_valid_o}, 64'h0);
        check("arst_resp_ready", {63'h0, dmi_resp_ready_o}, 64'h1);
        check("arst_req", {23'h0, dmi_req_o}, 64'h0);
        #4 rst_i = 1'b0;
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            update_i         = ($urandom_range(0, 5) == 0);
            capture_i        = ($urandom_range(0, 11) == 0);
            dmireset_i       = ($urandom_range(0, 39) == 0);
            dmihardreset_i   = ($urandom_range(0, 59) == 0);
            dmi_req_ready_i  = ($urandom_range(0, 1) == 0);
            dmi_resp_valid_i = ($urandom_range(0, 2) == 0);
            dmi_i            = {7'($urandom), 32'($urandom), 2'($urandom)};
            dmi_resp_i       = {32'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'h0};
            step();
        end
        clear_inputs();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
